feistel_decrypt: RTL and testbench

- Fully pipelined 5-round Feistel block decryptor on 256-bit blocks, split into 128-bit halves.
- Each round's F function uses an 8-bit S-box loaded serially at runtime and 128-bit round keys.
- Exact inverse of its sibling feistel_encrypt, which uses the same ports except plaintext in and ciphertext out.
- Sits after feistel_encrypt in the image-cipher datapath; accepts one block per cycle.

---
 rtl/feistel_pkg.sv | 34 +++
 rtl/feistel_round.sv | 97 +++++++++
 rtl/feistel_decrypt.sv | 101 ++++++++++
 tb/tb_feistel_decrypt.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/feistel_pkg.sv
// Shared definitions for the Feistel encrypt/decrypt datapath.
//   - Block/half/key/S-box widths and the F-function rotate amount.
//   - sbox_t: the full 256-entry S-box table as one packed bus.
//   - round_mode_e: selects the encrypt or decrypt mix in feistel_round.
//   - half_pair_t: a valid bit with the L/R halves travelling through a stage.
package feistel_pkg;

  localparam int unsigned DATA_WIDTH = 256;
  localparam int unsigned KEY_SIZE   = 128;
  localparam int unsigned SBOX_WIDTH = 8;
  localparam int unsigned HALF       = DATA_WIDTH / 2;
  localparam int unsigned SBOX_DEPTH = 1 << SBOX_WIDTH;
  localparam int unsigned N_BYTES    = HALF / SBOX_WIDTH;
  localparam int unsigned F_ROT      = 8;

  typedef logic [SBOX_DEPTH-1:0][SBOX_WIDTH-1:0] sbox_t;

  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } round_mode_e;

  typedef struct packed {
    logic            v;
    logic [HALF-1:0] l;
    logic [HALF-1:0] r;
  } half_pair_t;

  // Fixed left-rotate of a half block by F_ROT bits.
  function automatic logic [HALF-1:0] rotl_half(input logic [HALF-1:0] val);
    return (val << F_ROT) | (val >> (HALF - F_ROT));
  endfunction

endpackage

// File: rtl/feistel_round.sv
// One pipelined Feistel round, shared by the encryptor and decryptor.
//   F(X,K): x = X ^ K; y = per-byte S-box lookup of x; F = y ^ rotl(y, 8).
//   MODE_DEC: L' = R ^ F(L,K), R' = L.
//   MODE_ENC: L' = R,          R' = L ^ F(R,K).
// Stage 1 registers x, stage 2 registers y, stage 3 registers the mixed
// halves; F_LAT-3 plain delay stages follow.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   mode                enc/dec mix select
//   sbox                current S-box table contents
//   key                 round key
//   in_valid/in_l/in_r  incoming block halves and valid
//   out_valid/out_l/out_r  outgoing block halves and valid
module feistel_round
  import feistel_pkg::*;
#(
  parameter int unsigned F_LAT = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  round_mode_e         mode,
  input  sbox_t               sbox,
  input  logic [KEY_SIZE-1:0] key,
  input  logic                in_valid,
  input  logic [HALF-1:0]     in_l,
  input  logic [HALF-1:0]     in_r,
  output logic                out_valid,
  output logic [HALF-1:0]     out_l,
  output logic [HALF-1:0]     out_r
);

  half_pair_t      s1, s2, s3, mix_comb, stage_out;
  logic [HALF-1:0] x1, y2;
  logic [HALF-1:0] f_in, y_comb, f_comb;

  always_comb begin
    f_in = (mode == MODE_DEC) ? in_l : in_r;
  end

  always_comb begin
    y_comb = '0;
    for (int unsigned b = 0; b < N_BYTES; b++) begin
      y_comb[b*SBOX_WIDTH +: SBOX_WIDTH] = sbox[x1[b*SBOX_WIDTH +: SBOX_WIDTH]];
    end
  end

  always_comb begin
    f_comb     = y2 ^ rotl_half(y2);
    mix_comb   = '0;
    mix_comb.v = s2.v;
    if (mode == MODE_DEC) begin
      mix_comb.l = s2.r ^ f_comb;
      mix_comb.r = s2.l;
    end else begin
      mix_comb.l = s2.r;
      mix_comb.r = s2.l ^ f_comb;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      x1 <= '0;
      y2 <= '0;
    end else begin
      s1 <= '{v: in_valid, l: in_l, r: in_r};
      x1 <= f_in ^ key;
      s2 <= s1;
      y2 <= y_comb;
      s3 <= mix_comb;
    end
  end

  if (F_LAT > 3) begin : g_delay
    half_pair_t dly [F_LAT-3];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int unsigned i = 0; i < F_LAT - 3; i++) dly[i] <= '0;
      end else begin
        dly[0] <= s3;
        for (int unsigned i = 1; i < F_LAT - 3; i++) dly[i] <= dly[i-1];
      end
    end

    assign stage_out = dly[F_LAT-4];
  end else begin : g_no_delay
    assign stage_out = s3;
  end

  assign out_valid = stage_out.v;
  assign out_l     = stage_out.l;
  assign out_r     = stage_out.r;

endmodule

// File: rtl/feistel_decrypt.sv
// Fully pipelined 5-round Feistel block decryptor (256-bit blocks).
// Holds the runtime-loaded S-box table and the latched round keys; round j
// uses key KR(4-j) so this inverts feistel_encrypt. One block per cycle,
// ROUND*F_LAT cycles from tvalid sample to valid.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   sbox_out, sbox_valid  serial S-box load (auto-incrementing pointer)
//   key_valid, K0..K4     round key load (encrypt order)
//   tvalid, ciphertext    input block, L = [255:128], R = [127:0]
//   valid, plaintext      output block; plaintext holds while valid=0
module feistel_decrypt #(
  parameter int unsigned ROUND      = 5,
  parameter int unsigned F_LAT      = 6,
  parameter int unsigned SBOX_WIDTH = 8,
  parameter int unsigned KEY_SIZE   = 128,
  parameter int unsigned DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [SBOX_WIDTH-1:0] sbox_out,
  input  logic                  sbox_valid,
  input  logic                  key_valid,
  input  logic [KEY_SIZE-1:0]   K0,
  input  logic [KEY_SIZE-1:0]   K1,
  input  logic [KEY_SIZE-1:0]   K2,
  input  logic [KEY_SIZE-1:0]   K3,
  input  logic [KEY_SIZE-1:0]   K4,
  input  logic                  tvalid,
  input  logic [DATA_WIDTH-1:0] ciphertext,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] plaintext
);

  import feistel_pkg::*;

  sbox_t                 sbox_q;
  logic [SBOX_WIDTH-1:0] wr_ptr;
  logic [KEY_SIZE-1:0]   kr [ROUND];

  logic [HALF-1:0] l_ch [ROUND+1];
  logic [HALF-1:0] r_ch [ROUND+1];
  logic            v_ch [ROUND+1];

  // Reads in the same cycle as a write see the old entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sbox_q <= '0;
      wr_ptr <= '0;
    end else if (sbox_valid) begin
      sbox_q[wr_ptr] <= sbox_out;
      wr_ptr         <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < ROUND; i++) kr[i] <= '0;
    end else if (key_valid) begin
      kr[0] <= K0;
      kr[1] <= K1;
      kr[2] <= K2;
      kr[3] <= K3;
      kr[4] <= K4;
    end
  end

  assign v_ch[0] = tvalid;
  assign l_ch[0] = ciphertext[DATA_WIDTH-1:HALF];
  assign r_ch[0] = ciphertext[HALF-1:0];

  for (genvar j = 0; j < ROUND; j++) begin : g_round
    feistel_round #(
      .F_LAT (F_LAT)
    ) u_round (
      .clk       (clk),
      .reset_n   (reset_n),
      .mode      (MODE_DEC),
      .sbox      (sbox_q),
      .key       (kr[ROUND-1-j]),
      .in_valid  (v_ch[j]),
      .in_l      (l_ch[j]),
      .in_r      (r_ch[j]),
      .out_valid (v_ch[j+1]),
      .out_l     (l_ch[j+1]),
      .out_r     (r_ch[j+1])
    );
  end

  // The round stages are clocked at edges t..t+ROUND*F_LAT-1; this register
  // presents the block at edge t+ROUND*F_LAT and holds it across bubbles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid     <= 1'b0;
      plaintext <= '0;
    end else begin
      valid <= v_ch[ROUND];
      if (v_ch[ROUND]) plaintext <= {l_ch[ROUND], r_ch[ROUND]};
    end
  end

endmodule

// File: tb/tb_feistel_decrypt.sv
module tb_feistel_decrypt;

  localparam int unsigned LAT = 30;

  logic         clk        = 1'b0;
  logic         reset_n    = 1'b0;
  logic [7:0]   sbox_out   = '0;
  logic         sbox_valid = 1'b0;
  logic         key_valid  = 1'b0;
  logic [127:0] K0 = '0, K1 = '0, K2 = '0, K3 = '0, K4 = '0;
  logic         tvalid     = 1'b0;
  logic [255:0] ciphertext = '0;
  logic         valid;
  logic [255:0] plaintext;

  feistel_decrypt #(
    .ROUND      (5),
    .F_LAT      (6),
    .SBOX_WIDTH (8),
    .KEY_SIZE   (128),
    .DATA_WIDTH (256)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sbox_out   (sbox_out),
    .sbox_valid (sbox_valid),
    .key_valid  (key_valid),
    .K0         (K0),
    .K1         (K1),
    .K2         (K2),
    .K3         (K3),
    .K4         (K4),
    .tvalid     (tvalid),
    .ciphertext (ciphertext),
    .valid      (valid),
    .plaintext  (plaintext)
  );

  always #5 clk = ~clk;

  // Index of the next posedge (read on a negedge).
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Reference model state.
  logic [7:0]   sb [256];
  logic [127:0] km [5];
  logic [7:0]   ptr_m;

  // Observed outputs: only this monitor writes these queues.
  logic [255:0] got_data [$];
  int unsigned  got_edge [$];
  int           got_rd = 0;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      got_data.push_back(plaintext);
      got_edge.push_back(cyc - 1);
    end
  end

  logic [255:0] exp_data [$];
  int unsigned  exp_edge [$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] f_m(input logic [127:0] half, input logic [127:0] k);
    logic [127:0] x;
    logic [127:0] y;
    x = half ^ k;
    y = '0;
    for (int b = 0; b < 16; b++) y[8*b +: 8] = sb[x[8*b +: 8]];
    return y ^ ((y << 8) | (y >> 120));
  endfunction

  function automatic logic [255:0] dec_m(input logic [255:0] c);
    logic [127:0] l, r, nl;
    l = c[255:128];
    r = c[127:0];
    for (int j = 0; j < 5; j++) begin
      nl = r ^ f_m(l, km[4-j]);
      r  = l;
      l  = nl;
    end
    return {l, r};
  endfunction

  function automatic logic [255:0] enc_m(input logic [255:0] p);
    logic [127:0] l, r, nr;
    l = p[255:128];
    r = p[127:0];
    for (int i = 0; i < 5; i++) begin
      nr = l ^ f_m(r, km[i]);
      l  = r;
      r  = nr;
    end
    return {l, r};
  endfunction

  function automatic logic [127:0] rand128();
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) sb[i] = 8'h00;
    for (int i = 0; i < 5; i++) km[i] = '0;
    ptr_m = 8'h00;
    exp_data.delete();
    exp_edge.delete();
  endtask

  task automatic load_keys(input logic [127:0] k0, input logic [127:0] k1,
                           input logic [127:0] k2, input logic [127:0] k3,
                           input logic [127:0] k4);
    K0 = k0; K1 = k1; K2 = k2; K3 = k3; K4 = k4;
    key_valid = 1'b1;
    km[0] = k0; km[1] = k1; km[2] = k2; km[3] = k3; km[4] = k4;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] b);
    sbox_out   = b;
    sbox_valid = 1'b1;
    sb[ptr_m]  = b;
    ptr_m      = ptr_m + 8'd1;
    @(negedge clk);
    sbox_valid = 1'b0;
  endtask

  // Drive one cycle of input; called on a negedge.
  task automatic cyc_in(input logic v, input logic [255:0] c, input logic [255:0] exp);
    tvalid     = v;
    ciphertext = c;
    if (v) begin
      exp_data.push_back(exp);
      exp_edge.push_back(cyc + LAT);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [255:0] c);
    cyc_in(1'b1, c, dec_m(c));
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n_got;
    tvalid = 1'b0;
    for (int i = 0; i < LAT + 20 && (got_data.size() - got_rd) < exp_data.size(); i++)
      @(negedge clk);
    repeat (4) @(negedge clk);
    n_got = got_data.size() - got_rd;
    check($sformatf("%s_count", tag), 256'(n_got), 256'(exp_data.size()));
    for (int i = 0; i < exp_data.size(); i++) begin
      if (got_rd + i < got_data.size()) begin
        check($sformatf("%s_data%0d", tag, i), got_data[got_rd+i], exp_data[i]);
        check($sformatf("%s_edge%0d", tag, i), 256'(got_edge[got_rd+i]), 256'(exp_edge[i]));
      end
    end
    got_rd = got_data.size();
    exp_data.delete();
    exp_edge.delete();
  endtask

  initial begin
    logic [127:0] a, b;
    logic [127:0] kp [5];
    logic [255:0] pt [3];
    logic [255:0] ct;

    model_reset();
    repeat (3) @(negedge clk);
    check("reset_valid", {255'd0, valid}, '0);
    check("reset_plaintext", plaintext, '0);
    reset_n = 1'b1;
    @(negedge clk);

    // Zero S-box: F = 0 so every round swaps halves.
    for (int i = 0; i < 5; i++)
      for (int n = 0; n < 16; n++) kp[i][127-8*n -: 8] = 8'(i*16 + n);
    load_keys(kp[0], kp[1], kp[2], kp[3], kp[4]);
    a = {16{8'h11}};
    b = {16{8'h22}};
    cyc_in(1'b1, {a, b}, {b, a});
    drain("zero_sbox_swap");

    // Descending S-box, three back-to-back known plaintexts.
    for (int i = 0; i < 256; i++) load_byte(8'(255 - i));
    pt[0] = 256'h11223344556677889900AABBCCDDEEFF_00112233445566778899AABBCCDDEEFF;
    pt[1] = 256'hA1B2C3D4E5F60718293A4B5C6D7E8F90_102132435465768798A9BACBDCEDFE0F;
    pt[2] = 256'h55AA55AA33CC33CC0F0F0F0FF0F0F0F0_1234567890ABCDEF1122334455667788;
    for (int i = 0; i < 3; i++) cyc_in(1'b1, enc_m(pt[i]), pt[i]);
    drain("known_vectors");

    // Pulses at relative cycles 0,1,2,5.
    send({rand128(), rand128()});
    send({rand128(), rand128()});
    send({rand128(), rand128()});
    idle(2);
    send({rand128(), rand128()});
    drain("latency_pattern");

    // Reset mid-stream drops in-flight blocks.
    send({rand128(), rand128()});
    send({rand128(), rand128()});
    send({rand128(), rand128()});
    idle(7);
    reset_n = 1'b0;
    #1;
    check("midreset_valid", {255'd0, valid}, '0);
    check("midreset_plaintext", plaintext, '0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle(LAT + 10);
    check("midreset_no_output", 256'(got_data.size() - got_rd), '0);
    got_rd = got_data.size();

    // Pointer wrap: 257th byte lands in SBOX[0].
    for (int i = 0; i < 256; i++) load_byte(8'($urandom_range(0, 255)));
    load_byte(8'h5A);
    load_keys(rand128(), rand128(), rand128(), rand128(), rand128());
    send({km[4], rand128()});
    send({rand128(), rand128()});
    send({km[4] ^ 128'h00FF, rand128()});
    drain("sbox_wrap");

    // Key ports change without key_valid: latched keys stay in use.
    K0 = rand128(); K1 = rand128(); K2 = rand128(); K3 = rand128(); K4 = rand128();
    idle(2);
    for (int i = 0; i < 4; i++) begin
      ct = {rand128(), rand128()};
      send(ct);
    end
    drain("key_hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
